axi_wr_arbiter: RTL and testbench
=================================

# axi_wr_arbiter

Write-channel arbiter and scheduler for an N-to-1 AXI mux. It grants the AW channel among MASTER_NUM requesters in round-robin order and records each accepted AW's source index in an order FIFO. It then locks the W channel to the head master until that burst's WLAST handshake completes. It sits in front of the mux datapath: it only produces select and valid/ready sequencing, and the payload muxing stays in the datapath.

## Interface
- MASTER_NUM, 4: number of requesting masters; must be ≥1.
- W_FIFO_DEPTH, 4: maximum accepted AW bursts whose W data is not yet complete; must be a power of two and ≥2.
- IDX_W (derived): $clog2(MASTER_NUM), minimum 1.

- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  synchronous reset, active-low.
- m_aw_valid  in  MASTER_NUM  per-master AW valid.
- m_aw_ready  out  MASTER_NUM  per-master AW ready; one-hot or zero.
- s_aw_valid  out  1  AW valid toward the slave side.
- s_aw_ready  in  1  AW ready from the slave side.
- aw_sel  out  IDX_W  index of the granted master; meaningful only while s_aw_valid=1.
- m_w_valid  in  MASTER_NUM  per-master W valid.
- m_w_last  in  MASTER_NUM  per-master W last.
- m_w_ready  out  MASTER_NUM  per-master W ready; one-hot or zero.
- s_w_valid  out  1  W valid toward the slave side.
- s_w_last  out  1  equals m_w_last[w_sel].
- s_w_ready  in  1  W ready from the slave side.
- w_sel  out  IDX_W  index of the master owning W; equals the FIFO head.
- idle  out  1  high when the arbiter is in IDLE, the FIFO is empty and no request is present.

## Operation
- AW FSM has two states: IDLE and HOLD.
- IDLE behaviour:
  - If any m_aw_valid is set and the FIFO is not full, pick the first set bit scanning upward from rr_ptr with wrap-around.
  - Drive s_aw_valid=1 and aw_sel to that index.
  - m_aw_ready[aw_sel] = s_aw_ready.
  - If s_aw_ready=1, the handshake completes in the same cycle and the FSM stays in IDLE.
  - Otherwise, latch the grant and go to HOLD.
- HOLD behaviour:
  - Drive s_aw_valid=1 with aw_sel equal to the latched grant, regardless of other requests.
  - m_aw_ready[grant] = s_aw_ready.
  - On handshake, return to IDLE.
- On every AW handshake:
  - Push aw_sel into the order FIFO.
  - rr_ptr <= (aw_sel+1) mod MASTER_NUM.
- FIFO full in IDLE: s_aw_valid=0 and all m_aw_ready=0. No push is ever attempted when full, including in a cycle where a pop also occurs; full is evaluated from registered state.
- HOLD is only entered when the FIFO is not full. The FIFO cannot fill during HOLD.
- W path:
  - Empty FIFO: s_w_valid=0 and all m_w_ready=0. W never precedes its AW.
  - Non-empty FIFO: s_w_valid = m_w_valid[head], s_w_last = m_w_last[head], m_w_ready[head] = s_w_ready, all other m_w_ready=0.
  - A W handshake with s_w_last=1 pops the FIFO. Other beats do not change state.
- Same-cycle push and pop: both take effect and the count is unchanged. When the FIFO is empty, a push in cycle t makes W available in cycle t+1; there is no bypass.
- Counter arithmetic: FIFO pointers are $clog2(W_FIFO_DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the LSBs are equal.
- MASTER_NUM=1: aw_sel and w_sel are constant 0, and rr_ptr is unused.

## Timing
- AW grant latency: 0 cycles. Combinational from m_aw_valid to s_aw_valid in IDLE.
- W select latency: 1 cycle after the first AW handshake into an empty FIFO.
- Outputs depend combinationally on the valid/ready inputs and on registered state only.
- There is no combinational path from s_w_ready to any AW output, or from s_aw_ready to any W output.
- Throughput: one AW per cycle while the FIFO is not full. One W beat per cycle.
- Reset (rstn=0 at a rising edge), in effect from the next cycle:
  - FSM=IDLE, rr_ptr=0, FIFO empty.
  - s_aw_valid=0 unless a request is present. s_w_valid=0. All m_w_ready=0. idle=1 if there are no requests.
  - Reset mid-burst discards all queued and partial bursts without completing them.

## Test plan
- Round-robin fairness: MASTER_NUM=4, all m_aw_valid=1, s_aw_ready=1 -> aw_sel sequence 0,1,2,3,0; one handshake per cycle while W drains with single-beat bursts.
- Grant stability: master 2 requests, s_aw_ready=0 for 3 cycles, then master 0 raises valid -> aw_sel stays 2 until the handshake; next grant is 0 only if 3 is idle.
- W ordering: AW accepted from 1 then 3; master 3 presents W first -> m_w_ready[3]=0 until master 1's 4-beat burst ends with wlast; then w_sel=3.
- FIFO full: W_FIFO_DEPTH=4, 4 AWs accepted, s_w_ready=0 -> fifth AW sees s_aw_valid=0; one wlast handshake -> fifth AW accepted the cycle after the pop.
- Simultaneous push/pop: FIFO count 1, AW handshake and wlast pop in the same cycle -> count stays 1, head becomes the newly pushed index.
- Reset mid-operation: rstn=0 during beat 2 of a burst with 2 entries queued -> next cycle s_w_valid=0, idle=1, rr_ptr=0; a fresh request from 3 is granted immediately.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin AW grant with an order FIFO that locks W to the head master
module axi_wr_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int W_FIFO_DEPTH = 4,
  parameter int IDX_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [MASTER_NUM-1:0] m_aw_valid,
  output logic [MASTER_NUM-1:0] m_aw_ready,
  output logic                  s_aw_valid,
  input  logic                  s_aw_ready,
  output logic [IDX_W-1:0]      aw_sel,
  input  logic [MASTER_NUM-1:0] m_w_valid,
  input  logic [MASTER_NUM-1:0] m_w_last,
  output logic [MASTER_NUM-1:0] m_w_ready,
  output logic                  s_w_valid,
  output logic                  s_w_last,
  input  logic                  s_w_ready,
  output logic [IDX_W-1:0]      w_sel,
  output logic                  idle
);
  localparam int PW = $clog2(W_FIFO_DEPTH);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d, rr_q, rr_d, pick;
  logic [IDX_W-1:0] fifo_q [W_FIFO_DEPTH];
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic found, full, empty, aw_hs, pop;
  assign full = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign empty = wr_q == rd_q;
  assign w_sel = fifo_q[rd_q[PW-1:0]];
  assign idle = (state_q == IDLE) && empty && !(|m_aw_valid);
  // first requesting master at or above rr_q, wrapping around
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (!found && m_aw_valid[(int'(rr_q) + i) % MASTER_NUM]) begin
        found = 1'b1;
        pick = IDX_W'((int'(rr_q) + i) % MASTER_NUM);
      end
    end
  end
  // AW grant, hold-while-stalled FSM and round-robin pointer advance
  always_comb begin
    s_aw_valid = (state_q == HOLD) || (found && !full);
    aw_sel = (state_q == HOLD) ? grant_q : pick;
    m_aw_ready = s_aw_valid ? (MASTER_NUM'(s_aw_ready) << aw_sel) : '0;
    aw_hs = s_aw_valid && s_aw_ready;
    state_d = (state_q == IDLE) ? ((s_aw_valid && !s_aw_ready) ? HOLD : IDLE)
                                : (s_aw_ready ? IDLE : HOLD);
    grant_d = aw_sel;
    rr_d = aw_hs ? IDX_W'((int'(aw_sel) + 1) % MASTER_NUM) : rr_q;
  end
  // W steering to the FIFO head; a last-beat handshake retires the head entry
  always_comb begin
    s_w_valid = !empty && m_w_valid[w_sel];
    s_w_last = m_w_last[w_sel];
    m_w_ready = empty ? '0 : (MASTER_NUM'(s_w_ready) << w_sel);
    pop = s_w_valid && s_w_ready && s_w_last;
    wr_d = wr_q + (PW+1)'(aw_hs);
    rd_d = rd_q + (PW+1)'(pop);
  end
  // state, pointers and FIFO storage; reset drops every queued burst
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      for (int k = 0; k < W_FIFO_DEPTH; k++) fifo_q[k] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (aw_hs) fifo_q[wr_q[PW-1:0]] <= aw_sel;
    end
  end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: directed scenario checks for the AXI write arbiter
module tb_axi_wr_arbiter;
  logic clk = 1'b0;
  logic rstn;
  logic [3:0] m_aw_valid, m_aw_ready, m_w_valid, m_w_last, m_w_ready;
  logic s_aw_valid, s_aw_ready, s_w_valid, s_w_last, s_w_ready, idle;
  logic [1:0] aw_sel, w_sel;
  int pass_cnt = 0;
  int total = 0;

  axi_wr_arbiter #(.MASTER_NUM(4), .W_FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .aw_sel(aw_sel),
    .m_w_valid(m_w_valid), .m_w_last(m_w_last), .m_w_ready(m_w_ready),
    .s_w_valid(s_w_valid), .s_w_last(s_w_last), .s_w_ready(s_w_ready),
    .w_sel(w_sel), .idle(idle)
  );

  always #5 clk = ~clk;

  task clear_inputs();
    m_aw_valid = '0; s_aw_ready = 1'b0;
    m_w_valid = '0; m_w_last = '0; s_w_ready = 1'b0;
  endtask

  task do_reset();
    clear_inputs();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task test_reset();
    do_reset();
    #1;
    total++; if (s_aw_valid !== 1'b0) $display("FAIL reset s_aw_valid got %b want 0", s_aw_valid); else pass_cnt++;
    total++; if (m_aw_ready !== 4'b0) $display("FAIL reset m_aw_ready got %b want 0000", m_aw_ready); else pass_cnt++;
    total++; if (s_w_valid !== 1'b0) $display("FAIL reset s_w_valid got %b want 0", s_w_valid); else pass_cnt++;
    total++; if (m_w_ready !== 4'b0) $display("FAIL reset m_w_ready got %b want 0000", m_w_ready); else pass_cnt++;
    total++; if (idle !== 1'b1) $display("FAIL reset idle got %b want 1", idle); else pass_cnt++;
    @(negedge clk);
  endtask

  task test_round_robin();
    do_reset();
    m_aw_valid = 4'hF; s_aw_ready = 1'b1;
    m_w_valid = 4'hF; m_w_last = 4'hF; s_w_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (aw_sel !== 2'(c % 4)) $display("FAIL rr aw_sel cycle %0d got %0d want %0d", c, aw_sel, c % 4); else pass_cnt++;
      total++; if (m_aw_ready !== 4'(1 << (c % 4))) $display("FAIL rr m_aw_ready cycle %0d got %b want %b", c, m_aw_ready, 4'(1 << (c % 4))); else pass_cnt++;
      if (c == 0) begin
        total++; if (s_w_valid !== 1'b0) $display("FAIL rr no W bypass got %b want 0", s_w_valid); else pass_cnt++;
      end else begin
        total++; if (w_sel !== 2'((c - 1) % 4)) $display("FAIL rr w_sel cycle %0d got %0d want %0d", c, w_sel, (c - 1) % 4); else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task test_grant_stability();
    do_reset();
    m_aw_valid = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) m_aw_valid = 4'b0101;
      #1;
      total++; if (aw_sel !== 2'd2 || s_aw_valid !== 1'b1) $display("FAIL hold cycle %0d aw_sel got %0d/%b want 2/1", c, aw_sel, s_aw_valid); else pass_cnt++;
      total++; if (m_aw_ready !== 4'b0) $display("FAIL hold ready cycle %0d got %b want 0000", c, m_aw_ready); else pass_cnt++;
      @(negedge clk);
    end
    s_aw_ready = 1'b1;
    #1;
    total++; if (aw_sel !== 2'd2 || m_aw_ready !== 4'b0100) $display("FAIL hold release got %0d/%b want 2/0100", aw_sel, m_aw_ready); else pass_cnt++;
    @(negedge clk);
    m_aw_valid = 4'b1101;
    #1;
    total++; if (aw_sel !== 2'd3) $display("FAIL hold next with 3 got %0d want 3", aw_sel); else pass_cnt++;
    @(negedge clk);
    m_aw_valid = 4'b0101;
    #1;
    total++; if (aw_sel !== 2'd0) $display("FAIL hold wrap got %0d want 0", aw_sel); else pass_cnt++;
    @(negedge clk);
  endtask

  task test_w_ordering();
    do_reset();
    s_aw_ready = 1'b1;
    m_aw_valid = 4'b0010;
    #1;
    total++; if (aw_sel !== 2'd1) $display("FAIL ord first aw got %0d want 1", aw_sel); else pass_cnt++;
    @(negedge clk);
    m_aw_valid = 4'b1000;
    #1;
    total++; if (aw_sel !== 2'd3) $display("FAIL ord second aw got %0d want 3", aw_sel); else pass_cnt++;
    @(negedge clk);
    m_aw_valid = '0; s_w_ready = 1'b1;
    m_w_valid = 4'b1000; m_w_last = 4'b1000;
    #1;
    total++; if (m_w_ready !== 4'b0010 || s_w_valid !== 1'b0) $display("FAIL ord m3 blocked got %b/%b want 0010/0", m_w_ready, s_w_valid); else pass_cnt++;
    @(negedge clk);
    m_w_valid = 4'b1010;
    for (int b = 0; b < 4; b++) begin
      m_w_last = (b == 3) ? 4'b1010 : 4'b1000;
      #1;
      total++; if (w_sel !== 2'd1 || m_w_ready !== 4'b0010 || s_w_valid !== 1'b1 || s_w_last !== (b == 3)) $display("FAIL ord beat %0d got sel %0d rdy %b v %b l %b want 1 0010 1 %b", b, w_sel, m_w_ready, s_w_valid, s_w_last, b == 3); else pass_cnt++;
      @(negedge clk);
    end
    m_w_valid = 4'b1000; m_w_last = 4'b1000;
    #1;
    total++; if (w_sel !== 2'd3 || m_w_ready !== 4'b1000 || s_w_valid !== 1'b1) $display("FAIL ord m3 turn got %0d/%b/%b want 3/1000/1", w_sel, m_w_ready, s_w_valid); else pass_cnt++;
    @(negedge clk);
    #1;
    total++; if (s_w_valid !== 1'b0 || m_w_ready !== 4'b0) $display("FAIL ord drained got %b/%b want 0/0000", s_w_valid, m_w_ready); else pass_cnt++;
    @(negedge clk);
  endtask

  task test_fifo_full();
    do_reset();
    m_aw_valid = 4'b0001; s_aw_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (s_aw_valid !== 1'b1 || m_aw_ready !== 4'b0001) $display("FAIL full fill %0d got %b/%b want 1/0001", c, s_aw_valid, m_aw_ready); else pass_cnt++;
      @(negedge clk);
    end
    #1;
    total++; if (s_aw_valid !== 1'b0 || m_aw_ready !== 4'b0) $display("FAIL full blocked got %b/%b want 0/0000", s_aw_valid, m_aw_ready); else pass_cnt++;
    @(negedge clk);
    m_w_valid = 4'b0001; m_w_last = 4'b0001; s_w_ready = 1'b1;
    #1;
    total++; if (s_aw_valid !== 1'b0) $display("FAIL full pop cycle aw got %b want 0", s_aw_valid); else pass_cnt++;
    @(negedge clk);
    s_w_ready = 1'b0;
    #1;
    total++; if (s_aw_valid !== 1'b1 || m_aw_ready !== 4'b0001) $display("FAIL full after pop got %b/%b want 1/0001", s_aw_valid, m_aw_ready); else pass_cnt++;
    @(negedge clk);
    #1;
    total++; if (s_aw_valid !== 1'b0) $display("FAIL full refilled got %b want 0", s_aw_valid); else pass_cnt++;
    @(negedge clk);
  endtask

  task test_push_pop();
    do_reset();
    m_aw_valid = 4'b0100; s_aw_ready = 1'b1;
    @(negedge clk);
    m_aw_valid = 4'b0001;
    m_w_valid = 4'b0100; m_w_last = 4'b0100; s_w_ready = 1'b1;
    #1;
    total++; if (aw_sel !== 2'd0 || s_aw_valid !== 1'b1) $display("FAIL pp aw got %0d/%b want 0/1", aw_sel, s_aw_valid); else pass_cnt++;
    total++; if (w_sel !== 2'd2 || s_w_valid !== 1'b1 || s_w_last !== 1'b1) $display("FAIL pp w got %0d/%b/%b want 2/1/1", w_sel, s_w_valid, s_w_last); else pass_cnt++;
    @(negedge clk);
    m_aw_valid = '0; s_aw_ready = 1'b0;
    m_w_valid = 4'b0001; m_w_last = 4'b0001; s_w_ready = 1'b0;
    #1;
    total++; if (w_sel !== 2'd0 || s_w_valid !== 1'b1 || m_w_ready !== 4'b0) $display("FAIL pp head got %0d/%b/%b want 0/1/0000", w_sel, s_w_valid, m_w_ready); else pass_cnt++;
    s_w_ready = 1'b1;
    @(negedge clk);
    #1;
    total++; if (s_w_valid !== 1'b0 || idle !== 1'b1) $display("FAIL pp count one got %b/%b want 0/1", s_w_valid, idle); else pass_cnt++;
    @(negedge clk);
  endtask

  task test_reset_mid();
    do_reset();
    m_aw_valid = 4'b0111; s_aw_ready = 1'b1;
    repeat (3) @(negedge clk);
    m_aw_valid = '0;
    m_w_valid = 4'b0001; m_w_last = 4'b0000; s_w_ready = 1'b1;
    @(negedge clk);
    #1;
    total++; if (s_w_valid !== 1'b1 || w_sel !== 2'd0) $display("FAIL mid beat2 got %b/%0d want 1/0", s_w_valid, w_sel); else pass_cnt++;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    total++; if (s_w_valid !== 1'b0 || m_w_ready !== 4'b0) $display("FAIL mid flushed got %b/%b want 0/0000", s_w_valid, m_w_ready); else pass_cnt++;
    total++; if (idle !== 1'b1) $display("FAIL mid idle got %b want 1", idle); else pass_cnt++;
    m_w_valid = '0;
    m_aw_valid = 4'b1111;
    #1;
    total++; if (aw_sel !== 2'd0) $display("FAIL mid rr_ptr got %0d want 0", aw_sel); else pass_cnt++;
    m_aw_valid = 4'b1000;
    #1;
    total++; if (aw_sel !== 2'd3 || s_aw_valid !== 1'b1 || m_aw_ready !== 4'b1000) $display("FAIL mid fresh got %0d/%b/%b want 3/1/1000", aw_sel, s_aw_valid, m_aw_ready); else pass_cnt++;
    @(negedge clk);
    m_aw_valid = '0;
    #1;
    total++; if (w_sel !== 2'd3 || idle !== 1'b0) $display("FAIL mid queued got %0d/%b want 3/0", w_sel, idle); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_round_robin();
    test_grant_stability();
    test_w_ordering();
    test_fifo_full();
    test_push_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
